data_memory_be: RTL and testbench
=================================

// Module: data_memory_be
// PURPOSE
//  Parametrised, byte-addressed MIPS data memory for the MEM stage. Uses byte-lane write
//  enables with read-modify-preserve, a registered load path with sign/zero extension, and
//  misalignment detection. Includes a dump engine that streams every word to the debug
//  unit over a valid/ready handshake while the pipeline is halted.
// PARAMETERS
//  DATA_WIDTH   32  word width in bits; fixed at 32, 4 byte lanes
//  ADDR_WIDTH   32  byte-address width from the ALU
//  DEPTH_WORDS  64  number of words; power of 2, >= 2
// PORTS
//  i_clock        in   1           single clock; all state updates on the rising edge
//  i_reset        in   1           synchronous, active-high reset
//  i_address      in   ADDR_WIDTH  byte address
//  i_datawrite    in   DATA_WIDTH  store data, right-aligned (rt)
//  i_memread      in   1           load request
//  i_memwrite     in   1           store request
//  i_signed       in   1           1 = sign-extend load, 0 = zero-extend
//  i_size         in   2           01 = byte, 10 = halfword, 00/11 = word
//  o_dataread     out  DATA_WIDTH  registered, extended load data
//  o_misaligned   out  1           registered flag for the access presented last cycle
//  i_dump_start   in   1           one-cycle pulse from the debug unit; starts a dump
//  i_dump_ready   in   1           debug consumer accepts o_dump_data
//  o_dump_valid   out  1           dump beat valid
//  o_dump_data    out  DATA_WIDTH  dump word
//  o_dump_index   out  log2(DEPTH) word index of the current beat
//  o_dump_done    out  1           one-cycle pulse after the last beat
//  o_busy         out  1           high while the dump engine is not IDLE
// BEHAVIOUR
//  - Reset: all outputs go to 0 and the FSM goes to IDLE. Memory contents are NOT cleared.
//  - Addressing: word index = i_address[log2(DEPTH)+1:2]; lane offset = i_address[1:0].
//    Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
//  - Misaligned when: halfword with addr[0]=1, or word with addr[1:0]!=0. A byte access
//    is never misaligned.
//  - Store (i_memwrite, aligned, !o_busy): written at the edge. Byte: lane = offset.
//    Half: lanes {offset+1, offset}. Word: all lanes. Unselected lanes keep their value.
//  - Load (i_memread): o_dataread is valid 1 cycle later (latency 1). The selected lane(s)
//    are shifted to bit 0 and extended per i_signed. A word load ignores i_signed.
//  - When i_memread=0, o_dataread holds its previous value.
//  - Misaligned load/store: write suppressed; o_misaligned=1 and o_dataread=0 next cycle.
//  - Same-cycle read and write to the same word: the load returns the OLD contents
//    (read-before-write).
//  - While o_busy=1: pipeline reads and writes are ignored; o_dataread holds and
//    o_misaligned=0.
//  - Dump FSM: IDLE -start-> RD (registered read of word idx) -> SEND.
//    SEND: o_dump_valid=1; data and index stay stable until i_dump_ready.
//    On handshake: if idx==DEPTH-1 go to DONE, else idx++ and go to RD.
//    DONE: o_dump_done=1 for 1 cycle, then IDLE with idx=0.
//  - i_dump_start while busy is ignored. A full dump with ready held high takes
//    2*DEPTH+1 cycles from start to the done pulse.
//  - i_reset mid-dump: IDLE, valid=0, idx=0 on the next edge; memory is untouched.
// STRUCTURE
//  - Shared package mips_mem_pkg: SIZE_BYTE=2'b01, SIZE_HALF=2'b10, SIZE_WORD=2'b11,
//    dump FSM state encodings, clog2 function.
//  - Sub-module load_align_ext: combinational lane select plus sign/zero extension
//    (inputs: word, offset, size, signed). The memory array, write-enable logic and
//    dump FSM stay in the top module.
// TESTING
//  - SW 0xDEADBEEF @0x10, then SB 0x77 @0x11 -> LW @0x10 returns 0xDEAD77EF one cycle later.
//  - Mem[0x20]=0x00F080FF -> LB signed @0x20 = 0xFFFFFFFF; LBU @0x21 = 0x00000080;
//    LH signed @0x22 = 0x000000F0.
//  - LW @0x13 and SH @0x11 -> o_misaligned=1, o_dataread=0, memory word unchanged.
//  - DEPTH=4, words 1,2,3,4 loaded; start with ready=1 -> 4 beats (idx 0..3, data 1..4),
//    done pulse at cycle 9.
//  - Dump with ready low for 5 cycles on beat 2 -> valid, data and index held, no beat
//    lost or duplicated.
//  - Reset asserted mid-dump at idx=2 -> IDLE, valid=0; a new start dumps from idx 0 and
//    memory data is intact.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data memory: access sizes, dump FSM states and clog2.
package mips_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StSend = 2'd2,
    StDone = 2'd3
  } dump_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/data_memory_be_if.sv
// Pipeline access and debug dump signals of the data memory, seen from both ends.
interface data_memory_be_if
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 64
);
  localparam int unsigned IDX_W = clog2(DEPTH_WORDS);

  logic [ADDR_WIDTH-1:0] i_address;
  logic [DATA_WIDTH-1:0] i_datawrite;
  logic                  i_memread;
  logic                  i_memwrite;
  logic                  i_signed;
  logic [1:0]            i_size;
  logic [DATA_WIDTH-1:0] o_dataread;
  logic                  o_misaligned;
  logic                  i_dump_start;
  logic                  i_dump_ready;
  logic                  o_dump_valid;
  logic [DATA_WIDTH-1:0] o_dump_data;
  logic [IDX_W-1:0]      o_dump_index;
  logic                  o_dump_done;
  logic                  o_busy;

  modport slave (
    input  i_address, i_datawrite, i_memread, i_memwrite, i_signed, i_size,
    input  i_dump_start, i_dump_ready,
    output o_dataread, o_misaligned, o_dump_valid, o_dump_data, o_dump_index, o_dump_done,
    output o_busy
  );

  modport master (
    output i_address, i_datawrite, i_memread, i_memwrite, i_signed, i_size,
    output i_dump_start, i_dump_ready,
    input  o_dataread, o_misaligned, o_dump_valid, o_dump_data, o_dump_index, o_dump_done,
    input  o_busy
  );

endinterface

// File: rtl/load_align_ext.sv
// Selects the addressed byte/halfword of a memory word, right-aligns it and extends it.
module load_align_ext
  import mips_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[8*offset_i +: 8];
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    data_o   = word_i;
    unique case (size_i)
      SIZE_BYTE: data_o = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
      SIZE_HALF: data_o = {{16{sign_ext_i & half_sel[15]}}, half_sel};
      default:   data_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_memory_be.sv
// Byte-addressed MIPS data memory with lane write enables, registered extending loads
// and a halted-pipeline dump engine streaming every word over valid/ready.
module data_memory_be
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 64
) (
  input logic             i_clock,
  input logic             i_reset,
  data_memory_be_if.slave bus
);

  localparam int unsigned IDX_W = clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0]      word_idx;
  logic [1:0]            offset;
  logic                  busy;
  logic                  misaligned;
  logic                  access;
  logic                  write_en;
  logic [3:0]            lane_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] load_data;

  dump_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] dump_data_q;
  logic [DATA_WIDTH-1:0] dataread_q;
  logic                  misaligned_q;

  // Upper address bits wrap the address space and are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^bus.i_address[ADDR_WIDTH-1:IDX_W+2];

  assign word_idx = bus.i_address[IDX_W+1:2];
  assign offset   = bus.i_address[1:0];
  assign busy     = (state_q != StIdle);
  assign access   = !busy && (bus.i_memread || bus.i_memwrite);
  assign write_en = !busy && bus.i_memwrite && !misaligned;

  always_comb begin
    misaligned = 1'b0;
    lane_en    = 4'b1111;
    wdata      = bus.i_datawrite;
    unique case (bus.i_size)
      SIZE_BYTE: begin
        lane_en = 4'b0001 << offset;
        wdata   = {4{bus.i_datawrite[7:0]}};
      end
      SIZE_HALF: begin
        misaligned = offset[0];
        lane_en    = offset[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{bus.i_datawrite[15:0]}};
      end
      default: misaligned = (offset != 2'b00);
    endcase
  end

  // No reset on the array: contents survive i_reset.
  always_ff @(posedge i_clock) begin
    for (int l = 0; l < 4; l++) begin
      if (write_en && lane_en[l]) mem[word_idx][8*l +: 8] <= wdata[8*l +: 8];
    end
  end

  load_align_ext u_load_align_ext (
    .word_i     (mem[word_idx]),
    .offset_i   (offset),
    .size_i     (bus.i_size),
    .sign_ext_i (bus.i_signed),
    .data_o     (load_data)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      dataread_q   <= '0;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= access && misaligned;
      if (access && misaligned) begin
        dataread_q <= '0;
      end else if (!busy && bus.i_memread) begin
        dataread_q <= load_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: if (bus.i_dump_start) state_d = StRd;
      StRd:   state_d = StSend;
      StSend: begin
        if (bus.i_dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StRd;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        idx_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      dump_data_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == StRd) dump_data_q <= mem[idx_q];
    end
  end

  assign bus.o_dataread   = dataread_q;
  assign bus.o_misaligned = misaligned_q;
  assign bus.o_dump_valid = (state_q == StSend);
  assign bus.o_dump_data  = dump_data_q;
  assign bus.o_dump_index = idx_q;
  assign bus.o_dump_done  = (state_q == StDone);
  assign bus.o_busy       = busy;

endmodule

// File: tb/tb_data_memory_be.sv
// Self-checking bench for data_memory_be: byte-array reference model, directed and random
// pipeline accesses, and dump sequences with stalls, busy-time traffic and mid-dump reset.
module tb_data_memory_be;
  import mips_mem_pkg::*;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned NBYTES = 4 * DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_memory_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH)) bus ();

  data_memory_be #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  logic [7:0]  ref_mem [NBYTES];
  logic [31:0] exp_data = '0;
  logic        exp_mis  = 1'b0;
  bit          ref_busy = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_mis(input logic [31:0] a, input logic [1:0] s);
    if (s == SIZE_BYTE) return 1'b0;
    if (s == SIZE_HALF) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] ref_word(input int b);
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s,
                                           input logic sg);
    int b;
    logic [7:0]  v;
    logic [15:0] h;
    b = int'(a % NBYTES);
    if (s == SIZE_BYTE) begin
      v = ref_mem[b];
      return sg ? {{24{v[7]}}, v} : {24'b0, v};
    end
    if (s == SIZE_HALF) begin
      h = {ref_mem[b+1], ref_mem[b]};
      return sg ? {{16{h[15]}}, h} : {16'b0, h};
    end
    return ref_word(b);
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    int b;
    int n;
    b = int'(a % NBYTES);
    n = (s == SIZE_BYTE) ? 1 : (s == SIZE_HALF) ? 2 : 4;
    for (int i = 0; i < n; i++) ref_mem[b+i] = d[8*i +: 8];
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [1:0] s, input logic sg, input logic [31:0] d);
    bus.i_memread   = rd;
    bus.i_memwrite  = wr;
    bus.i_address   = a;
    bus.i_size      = s;
    bus.i_signed    = sg;
    bus.i_datawrite = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, SIZE_WORD, 1'b0, 32'h0);
  endtask

  // One clock: predict from the inputs now presented, then check just after the edge.
  task automatic cycle();
    logic [31:0] nd;
    logic        nm;
    nd = exp_data;
    nm = 1'b0;
    if (rst) begin
      nd = '0;
    end else if (!ref_busy && (bus.i_memread || bus.i_memwrite)) begin
      if (is_mis(bus.i_address, bus.i_size)) begin
        nd = '0;
        nm = 1'b1;
      end else begin
        if (bus.i_memread) nd = ref_load(bus.i_address, bus.i_size, bus.i_signed);
        if (bus.i_memwrite) ref_store(bus.i_address, bus.i_size, bus.i_datawrite);
      end
    end
    @(posedge clk);
    #1;
    exp_data = nd;
    exp_mis  = nm;
    check("dataread", bus.o_dataread, exp_data);
    check("misaligned", 32'(bus.o_misaligned), 32'(exp_mis));
  endtask

  // Consumes a whole dump; reset_beat >= 0 aborts with i_reset once that beat is offered.
  task automatic run_dump(input int stall_beat, input int stall_len, input int reset_beat);
    int beats;
    int stalled;
    int cyc;
    bit done_seen;
    bit acc;
    beats     = 0;
    stalled   = 0;
    cyc       = 0;
    done_seen = 1'b0;
    idle();
    bus.i_dump_ready = 1'b0;
    bus.i_dump_start = 1'b1;
    cycle();
    bus.i_dump_start = 1'b0;
    ref_busy = 1'b1;
    while (!done_seen && cyc < 4 * DEPTH + 64) begin
      if (bus.o_dump_valid && beats == reset_beat) begin
        idle();
        bus.i_dump_ready = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        ref_busy = 1'b0;
        check("rst_valid", 32'(bus.o_dump_valid), 32'd0);
        check("rst_index", 32'(bus.o_dump_index), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_done", 32'(bus.o_dump_done), 32'd0);
        check("rst_dump_data", bus.o_dump_data, 32'd0);
        return;
      end
      check("busy", 32'(bus.o_busy), 32'd1);
      // Pipeline traffic and repeated starts while busy must have no effect.
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
      bus.i_dump_start = 1'($urandom_range(0, 1));
      bus.i_dump_ready = !(bus.o_dump_valid && beats == stall_beat && stalled < stall_len);
      if (bus.o_dump_valid) begin
        check("dump_data", bus.o_dump_data, ref_word(4 * beats));
        check("dump_index", 32'(bus.o_dump_index), 32'(beats));
        if (!bus.i_dump_ready) stalled++;
      end
      acc = bus.o_dump_valid && bus.i_dump_ready;
      cycle();
      cyc++;
      if (acc) beats++;
      if (bus.o_dump_done) done_seen = 1'b1;
    end
    check("dump_done_seen", 32'(done_seen), 32'd1);
    check("dump_beats", 32'(beats), 32'(DEPTH));
    check("dump_cycles", 32'(cyc), 32'(2 * DEPTH + stall_len));
    idle();
    bus.i_dump_start = 1'b0;
    bus.i_dump_ready = 1'b0;
    ref_busy = 1'b0;
    cycle();
    check("done_one_cycle", 32'(bus.o_dump_done), 32'd0);
    check("idle_after_done", 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    idle();
    bus.i_dump_start = 1'b0;
    bus.i_dump_ready = 1'b0;
    rst = 1'b1;
    cycle();
    cycle();
    check("reset_valid", 32'(bus.o_dump_valid), 32'd0);
    check("reset_done", 32'(bus.o_dump_done), 32'd0);
    check("reset_busy", 32'(bus.o_busy), 32'd0);
    check("reset_index", 32'(bus.o_dump_index), 32'd0);
    check("reset_dump_data", bus.o_dump_data, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 32'(4 * i), SIZE_WORD, 1'b0, $urandom);
      cycle();
    end

    drive(1'b0, 1'b1, 32'h10, SIZE_WORD, 1'b0, 32'hDEADBEEF);
    cycle();
    drive(1'b0, 1'b1, 32'h11, SIZE_BYTE, 1'b0, 32'hABCDEF77);
    cycle();
    drive(1'b1, 1'b0, 32'h10, SIZE_WORD, 1'b1, 32'h0);
    cycle();
    check("sb_merge", bus.o_dataread, 32'hDEAD77EF);

    drive(1'b0, 1'b1, 32'h20, SIZE_WORD, 1'b0, 32'h00F080FF);
    cycle();
    drive(1'b1, 1'b0, 32'h20, SIZE_BYTE, 1'b1, 32'h0);
    cycle();
    check("lb", bus.o_dataread, 32'hFFFFFFFF);
    drive(1'b1, 1'b0, 32'h21, SIZE_BYTE, 1'b0, 32'h0);
    cycle();
    check("lbu", bus.o_dataread, 32'h00000080);
    drive(1'b1, 1'b0, 32'h22, SIZE_HALF, 1'b1, 32'h0);
    cycle();
    check("lh", bus.o_dataread, 32'h000000F0);

    drive(1'b1, 1'b0, 32'h13, SIZE_WORD, 1'b0, 32'h0);
    cycle();
    check("lw_mis_flag", 32'(bus.o_misaligned), 32'd1);
    check("lw_mis_data", bus.o_dataread, 32'h0);
    drive(1'b0, 1'b1, 32'h11, SIZE_HALF, 1'b0, 32'h00001234);
    cycle();
    check("sh_mis_flag", 32'(bus.o_misaligned), 32'd1);
    drive(1'b1, 1'b0, 32'h10, 2'b00, 1'b1, 32'h0);
    cycle();
    check("sh_mis_untouched", bus.o_dataread, 32'hDEAD77EF);

    idle();
    cycle();
    cycle();
    check("hold", bus.o_dataread, 32'hDEAD77EF);

    drive(1'b1, 1'b1, 32'h10, SIZE_WORD, 1'b0, 32'hCAFEF00D);
    cycle();
    check("read_before_write", bus.o_dataread, 32'hDEAD77EF);
    drive(1'b1, 1'b0, 32'h10, SIZE_WORD, 1'b0, 32'h0);
    cycle();
    check("write_landed", bus.o_dataread, 32'hCAFEF00D);

    drive(1'b0, 1'b1, 32'hFFFFFF48, SIZE_WORD, 1'b0, 32'h5A5A1234);
    cycle();
    drive(1'b1, 1'b0, 32'h08, SIZE_WORD, 1'b0, 32'h0);
    cycle();
    check("addr_wrap", bus.o_dataread, 32'h5A5A1234);

    repeat (300) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
      cycle();
    end

    run_dump(-1, 0, -1);
    run_dump(2, 5, -1);
    run_dump(-1, 0, 2);
    run_dump(-1, 0, -1);

    repeat (50) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
